// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
package param_fifo_pkg;

   // Defaults match the fixed 16x8 lab FIFO this block replaces.
   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 16;

   // Occupancy needs one extra bit so that DEPTH itself is representable.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write, registered read with enable.
// The read register clears on reset; the array itself is never cleared.
module fifo_ram
   import param_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port: store on enable only.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: old contents are returned when reading and writing the same address.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with occupancy count, programmable almost-full/empty levels
// and optional sticky overflow/underflow flags (enabled by defining PARAM_FIFO_STICKY_ERR_EN).
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         read,
   input  logic                         write,
   input  logic [WIDTH-1:0]             inputBus,
   output logic [WIDTH-1:0]             outputBus,
   output logic                         empty,
   output logic                         full,
   output logic                         almostFull,
   output logic                         almostEmpty,
   output logic [cnt_width(DEPTH)-1:0]  count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = cnt_width(DEPTH);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en;
   logic              rd_en;

   // Accept rules: a write into a full FIFO is allowed only when a read frees the slot.
   always_comb begin
      wr_en = write & (~full | read);
      rd_en = read & ~empty;
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state; reset wins over any same-cycle request.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Status flags decode only the registered count, so they never glitch.
   always_comb begin
      count       = count_q;
      empty       = (count_q == '0);
      full        = (count_q == DEPTH_CNT);
      almostFull  = (count_q >= AF_CNT);
      almostEmpty = (count_q <= AE_CNT);
   end

   fifo_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .rst_i   (reset),
      .we_i    (wr_en & ~reset),
      .waddr_i (wr_ptr_q),
      .wdata_i (inputBus),
      .re_i    (rd_en & ~reset),
      .raddr_i (rd_ptr_q),
      .rdata_o (outputBus)
   );

`ifdef PARAM_FIFO_STICKY_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // Error flags latch on a rejected request and hold until reset.
   always_comb begin
      ovf_d = ovf_q | (write & full & ~read);
      unf_d = unf_q | (read & empty);
   end

   // Sticky error state.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
